// File: rtl/alarm_time_adjust.sv
// Alarm hour/minute setter: synchronised up/down buttons with press-and-hold auto-repeat.
// Optional feature macro ALARM_CARRY_EN: minute wraps carry/borrow into the hour field.
module alarm_time_adjust #(
    parameter int FIELD_W       = 6,
    parameter int HOUR_MAX      = 23,
    parameter int MIN_MAX       = 59,
    parameter int INIT_HOUR     = 0,
    parameter int INIT_MIN      = 0,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic [3:0]         btn,
    output logic [FIELD_W-1:0] a_hour,
    output logic [FIELD_W-1:0] a_min,
    output logic               step,
    output logic               repeating
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [FIELD_W-1:0] HOUR_TOP    = FIELD_W'(HOUR_MAX);
    localparam logic [FIELD_W-1:0] MIN_TOP     = FIELD_W'(MIN_MAX);
    localparam logic [FIELD_W-1:0] HOUR_RST    = FIELD_W'(INIT_HOUR);
    localparam logic [FIELD_W-1:0] MIN_RST     = FIELD_W'(INIT_MIN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         s1, s2, p;
    logic [3:0]         held, held_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               do_step;
    logic               one_hot;
    logic               press;
    logic               abort;
    logic [FIELD_W-1:0] hour_nxt, min_nxt;

    function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] top);
        return (v == top) ? '0 : v + FIELD_W'(1);
    endfunction

    function automatic logic [FIELD_W-1:0] wrap_dec(input logic [FIELD_W-1:0] v,
                                                    input logic [FIELD_W-1:0] top);
        return (v == '0) ? top : v - FIELD_W'(1);
    endfunction

    // Synchroniser keeps running regardless of enb so a re-enable sees fresh levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            p  <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            p  <= s2;
        end
    end

    assign one_hot = (s2 != 4'b0000) && ((s2 & (s2 - 4'd1)) == 4'b0000);
    assign press   = one_hot && (p == 4'b0000) && enb;
    assign abort   = (s2 != held) || !enb || !one_hot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            held  <= held_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        held_nxt  = held;
        do_step   = 1'b0;
        case (state)
            IDLE: begin
                if (press) begin
                    do_step   = 1'b1;
                    cnt_nxt   = '0;
                    held_nxt  = s2;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == HOLD_LAST) begin
                    do_step   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REPEAT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == REPEAT_LAST) begin
                    do_step = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // A step only fires when s2 is one-hot and equals the latched button, so s2 selects the action.
    always_comb begin
        hour_nxt = a_hour;
        min_nxt  = a_min;
        if (do_step) begin
            case (s2)
                4'b0001: begin
                    min_nxt = wrap_dec(a_min, MIN_TOP);
`ifdef ALARM_CARRY_EN
                    if (a_min == '0) hour_nxt = wrap_dec(a_hour, HOUR_TOP);
`endif
                end
                4'b0010: hour_nxt = wrap_dec(a_hour, HOUR_TOP);
                4'b0100: begin
                    min_nxt = wrap_inc(a_min, MIN_TOP);
`ifdef ALARM_CARRY_EN
                    if (a_min == MIN_TOP) hour_nxt = wrap_inc(a_hour, HOUR_TOP);
`endif
                end
                4'b1000: hour_nxt = wrap_inc(a_hour, HOUR_TOP);
                default: begin
                    hour_nxt = a_hour;
                    min_nxt  = a_min;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hour <= HOUR_RST;
            a_min  <= MIN_RST;
            step   <= 1'b0;
        end else begin
            a_hour <= hour_nxt;
            a_min  <= min_nxt;
            step   <= do_step;
        end
    end

    assign repeating = (state == REPEAT);

endmodule

// File: tb/tb_alarm_time_adjust.sv
// Scoreboard bench for alarm_time_adjust with short hold/repeat timing (HOLD=8, REPEAT=4).
module tb_alarm_time_adjust;

    localparam int FW = 6;

    logic          clk;
    logic          rst;
    logic          enb;
    logic [3:0]    btn;
    logic [FW-1:0] a_hour;
    logic [FW-1:0] a_min;
    logic          step;
    logic          repeating;

    logic [2*FW-1:0] exp_q[$];
    int              tests;
    int              fails;
    int              rep_cycles;
    logic [FW-1:0]   exp_h;
    logic [FW-1:0]   exp_m;

    alarm_time_adjust #(
        .FIELD_W(FW),
        .HOUR_MAX(23),
        .MIN_MAX(59),
        .INIT_HOUR(0),
        .INIT_MIN(0),
        .HOLD_CYCLES(8),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enb(enb),
        .btn(btn),
        .a_hour(a_hour),
        .a_min(a_min),
        .step(step),
        .repeating(repeating)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Expected-value model: each call predicts one step and queues the resulting fields.
    task automatic model_step(input int b);
        case (b)
            0: begin
`ifdef ALARM_CARRY_EN
                if (exp_m == 0) exp_h = (exp_h == 0) ? 6'd23 : exp_h - 6'd1;
`endif
                exp_m = (exp_m == 0) ? 6'd59 : exp_m - 6'd1;
            end
            1: exp_h = (exp_h == 0) ? 6'd23 : exp_h - 6'd1;
            2: begin
`ifdef ALARM_CARRY_EN
                if (exp_m == 59) exp_h = (exp_h == 23) ? 6'd0 : exp_h + 6'd1;
`endif
                exp_m = (exp_m == 59) ? 6'd0 : exp_m + 6'd1;
            end
            default: exp_h = (exp_h == 23) ? 6'd0 : exp_h + 6'd1;
        endcase
        exp_q.push_back({exp_h, exp_m});
    endtask

    task automatic tap(input int b);
        @(negedge clk) btn = 4'(1 << b);
        @(negedge clk) btn = 4'b0000;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_h = 6'd0;
        exp_m = 6'd0;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every step pulse must match the oldest queued prediction.
    always @(negedge clk) begin
        if (repeating) rep_cycles++;
        if (!rst && step) begin
            if (exp_q.size() == 0) begin
                check("unexpected_step", {20'd0, a_hour, a_min}, 32'hFFFF_FFFF);
            end else begin
                check("step_fields", {20'd0, a_hour, a_min}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rep_cycles = 0;
        exp_h = 6'd0;
        exp_m = 6'd0;
        rst = 1'b1;
        enb = 1'b1;
        btn = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_hour", 32'(a_hour), 0);
        check("rst_min", 32'(a_min), 0);
        check("rst_step", 32'(step), 0);
        check("rst_repeating", 32'(repeating), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single tap of min-up: field and step appear after the second edge.
        model_step(2);
        btn = 4'b0100;
        @(negedge clk) btn = 4'b0000;
        check("lat_e0_step", 32'(step), 0);
        @(negedge clk);
        check("lat_e1_min", 32'(a_min), 0);
        @(negedge clk);
        check("lat_e2_step", 32'(step), 1);
        check("lat_e2_min", 32'(a_min), 1);
        @(negedge clk);
        check("lat_e3_step", 32'(step), 0);
        check("lat_hour", 32'(a_hour), 0);
        repeat (4) @(negedge clk);

        // Hold hour-up for 20 cycles: steps at t, t+8, t+12, t+16, REPEAT for 12 cycles.
        rep_cycles = 0;
        repeat (4) model_step(3);
        btn = 4'b1000;
        repeat (20) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        check("hold_rep_cycles", 32'(rep_cycles), 12);
        check("hold_hour", 32'(a_hour), 4);
        check("hold_repeating_off", 32'(repeating), 0);

        // Wrap cases from 00:00 and 23:59.
        do_reset();
        model_step(0);
        tap(0);
`ifdef ALARM_CARRY_EN
        check("wrap_down_hour", 32'(a_hour), 23);
`else
        check("wrap_down_hour", 32'(a_hour), 0);
        model_step(1);
        tap(1);
`endif
        check("wrap_down_min", 32'(a_min), 59);
        check("pre_up_hour", 32'(a_hour), 23);
        model_step(2);
        tap(2);
        check("wrap_up_min", 32'(a_min), 0);
`ifdef ALARM_CARRY_EN
        check("wrap_up_hour", 32'(a_hour), 0);
`else
        check("wrap_up_hour", 32'(a_hour), 23);
`endif

        // Chord during HOLD aborts; dropping back to one button must not restart.
        model_step(2);
        @(negedge clk) btn = 4'b0100;
        repeat (3) @(negedge clk);
        btn = 4'b1100;
        repeat (5) @(negedge clk);
        btn = 4'b0100;
        repeat (15) @(negedge clk);
        btn = 4'b0000;
        repeat (5) @(negedge clk);
        check("chord_min", 32'(a_min), 1);
        check("chord_queue", 32'(exp_q.size()), 0);
        model_step(2);
        tap(2);
        check("chord_retap_min", 32'(a_min), 2);

        // Disabled adjust ignores presses.
        enb = 1'b0;
        tap(2);
        check("enb_off_min", 32'(a_min), 32'(exp_m));
        check("enb_off_hour", 32'(a_hour), 32'(exp_h));
        enb = 1'b1;
        repeat (3) @(negedge clk);

        // Reset during REPEAT with button held, then exactly one fresh step.
        model_step(3);
        model_step(3);
        @(negedge clk) btn = 4'b1000;
        repeat (12) @(negedge clk);
        check("pre_rst_repeating", 32'(repeating), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_hour", 32'(a_hour), 0);
        check("mid_rst_min", 32'(a_min), 0);
        check("mid_rst_repeating", 32'(repeating), 0);
        exp_h = 6'd0;
        exp_m = 6'd0;
        repeat (2) @(negedge clk);
        check("mid_rst_step", 32'(step), 0);
        model_step(3);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_e0_step", 32'(step), 0);
        @(negedge clk);
        check("post_rst_e1_step", 32'(step), 0);
        @(negedge clk);
        check("post_rst_e2_step", 32'(step), 1);
        check("post_rst_e2_hour", 32'(a_hour), 1);
        repeat (3) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        check("post_rst_hour", 32'(a_hour), 1);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
